muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative unsigned multiply / divide unit for a simple pipeline.  One
// operation is accepted from IDLE, runs for WIDTH single-cycle iterations
// (shift-add multiply or restoring divide), then presents its result for one
// DONE cycle before returning to IDLE.  Results hold until the next DONE.
//
// Ports
//   clk          single clock, rising-edge state updates
//   rst          asynchronous active-high reset
//   start        operation request, sampled on the rising edge of clk
//   control      op code: 4'b0010 multiply, 4'b0011 divide, others ignored
//   a, b         operands (multiplicand/multiplier or dividend/divisor)
//   busy         high whenever the sequencer is not IDLE (pipeline stall)
//   done         one-cycle result-valid pulse
//   op1          product low half or quotient
//   r15          product high half or remainder
//   div_by_zero  set when a divide was accepted with b == 0
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] op1,
   output logic [WIDTH-1:0] r15,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [3:0]    OP_MUL    = 4'b0010;
   localparam logic [3:0]    OP_DIV    = 4'b0011;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [3:0]       ctrl_q,  ctrl_d;
   // hi/lo form the working register pair shared by both operations:
   //   multiply: {hi, lo} is the running product, lo starts as the multiplier
   //   divide:   hi is the partial remainder, lo shifts dividend out / quotient in
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] lo_q,    lo_d;
   logic [WIDTH-1:0] op1_q,   op1_d;
   logic [WIDTH-1:0] r15_q,   r15_d;
   logic             dbz_q,   dbz_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_fits;

   // Datapath for a single iteration of either algorithm.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : {WIDTH{1'b0}})};
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      div_fits  = (div_shift >= {1'b0, b_q});
   end

   // Next-state and next-output logic.  op1/r15 are only written on the
   // transition into DONE so partial values never reach the outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      op1_d   = op1_q;
      r15_d   = r15_q;
      dbz_d   = dbz_q;

      case (state_q)
         IDLE: begin
            if (start && (control == OP_MUL || control == OP_DIV)) begin
               a_d    = a;
               b_d    = b;
               ctrl_d = control;
               cnt_d  = '0;
               dbz_d  = 1'b0;
               hi_d   = '0;
               lo_d   = (control == OP_MUL) ? b : a;
               state_d = (control == OP_MUL) ? MUL : DIV;
            end
         end

         MUL, DIV: begin
            if (state_q == DIV && b_q == '0) begin
               // Divide by zero skips the iterations entirely.
               state_d = DONE;
               op1_d   = '1;
               r15_d   = a_q;
               dbz_d   = 1'b1;
            end else begin
               if (ctrl_q == OP_DIV) begin
                  hi_d = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                  lo_d = {lo_q[WIDTH-2:0], div_fits};
               end else begin
                  hi_d = mul_sum[WIDTH:1];
                  lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_ITER) begin
                  state_d = DONE;
                  op1_d   = lo_d;
                  r15_d   = hi_d;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // All state and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         op1_q   <= '0;
         r15_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         op1_q   <= op1_d;
         r15_q   <= r15_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign op1         = op1_q;
   assign r15         = r15_q;
   assign div_by_zero = dbz_q;

endmodule
